// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared definitions for the instruction-memory boot loader:
//   - state_t        : loader FSM state encoding
//   - BYTES_PER_WORD : boot-stream bytes per 32-bit instruction word
//   - BYTE_IDX_W     : width of the byte-within-word index
//   - DEFAULT_ADDR_W / DEFAULT_DEPTH : default memory geometry
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
    localparam int DEFAULT_ADDR_W = 8;
    localparam int DEFAULT_DEPTH  = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// imem_byte_packer
// Assembles little-endian 32-bit words from a byte stream.
// Ports:
//   clk       in   system clock
//   clear     in   synchronous clear of byte index and assembly register
//   push      in   accept byte_data into the current byte lane
//   byte_data in   8-bit payload
//   word      out  assembly register (holds last assembled word between loads)
//   last_byte out  high when the byte being pushed completes a word
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        last_byte
);

    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    logic [BYTE_IDX_W-1:0] byte_idx;

    // NOTE: flops use non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clear) begin
            byte_idx <= '0;
            word     <= '0;
        end else if (push) begin
            // Byte k lands in bits [8k+7:8k]; the index wraps 3->0 naturally.
            word[8*byte_idx +: 8] <= byte_data;
            byte_idx              <= byte_idx + BYTE_IDX_W'(1);
        end
    end

    assign last_byte = push && (byte_idx == LAST_IDX);

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Loads instruction memory from a boot byte stream, stalling the core
// while the load is in progress.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle load request (honoured only in IDLE)
//   word_count      words to load, clamped to DEPTH; 0 completes immediately
//   byte_valid/byte_data/byte_ready  boot byte stream handshake
//   pc_address      core fetch address, routed to memory when not loading
//   mem_enable/mem_address/mem_data_in  instruction memory write port
//   cpu_hold        core stall while loading
//   done            one-cycle completion pulse
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic [ADDR_W-1:0] pc_address,
    output logic              mem_enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data_in,
    output logic              cpu_hold,
    output logic              done
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] word_idx;
    logic [ADDR_W:0]   last_idx;     // clamped count minus one
    logic [ADDR_W:0]   eff_count;
    logic              push;
    logic              last_byte;
    logic              at_last_word;

    assign eff_count    = (word_count > DEPTH_CNT) ? DEPTH_CNT : word_count;
    assign push         = byte_valid && byte_ready;
    assign at_last_word = ({1'b0, word_idx} == last_idx);

    // Reset clears the assembly register so mem_data_in reads 0 afterwards
    // and a half-built word cannot survive into a later load.
    imem_byte_packer u_packer (
        .clk       (clk),
        .clear     (rst),
        .push      (push),
        .byte_data (byte_data),
        .word      (mem_data_in),
        .last_byte (last_byte)
    );

    // NOTE: state_next gets a default before the case so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (word_count != '0) ? COLLECT : DONE;
            COLLECT: if (last_byte) state_next = WRITE;
            WRITE:   state_next = at_last_word ? DONE : COLLECT;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            word_idx <= '0;
            last_idx <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start && word_count != '0) begin
                word_idx <= '0;
                last_idx <= eff_count - (ADDR_W+1)'(1);
            end else if (state == WRITE && !at_last_word) begin
                word_idx <= word_idx + ADDR_W'(1);
            end
        end
    end

    assign byte_ready  = (state == COLLECT);
    assign mem_enable  = (state == WRITE);
    assign cpu_hold    = (state == COLLECT) || (state == WRITE);
    assign done        = (state == DONE);
    // Loader owns the shared address port only while holding the core.
    assign mem_address = cpu_hold ? word_idx : pc_address;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W:0]   word_count = '0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = '0;
    logic              byte_ready;
    logic [ADDR_W-1:0] pc_address = '0;
    logic              mem_enable;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_data_in;
    logic              cpu_hold;
    logic              done;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .word_count  (word_count),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .pc_address  (pc_address),
        .mem_enable  (mem_enable),
        .mem_address (mem_address),
        .mem_data_in (mem_data_in),
        .cpu_hold    (cpu_hold),
        .done        (done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (byte-counting view of a load) ----
    bit          m_ok = 1'b0;
    bit          m_busy, m_wr, m_dn;
    int          m_widx, m_target;
    logic [7:0]  m_q[$];
    logic [31:0] m_word, m_last;
    int          cyc = 0;

    task automatic model_loop();
        forever begin
            @(posedge clk);
            cyc++;
            m_ok = 1'b1;
            if (rst) begin
                m_busy = 0; m_wr = 0; m_dn = 0; m_widx = 0;
                m_q.delete(); m_last = '0; m_word = '0;
            end else if (m_wr) begin
                m_wr   = 0;
                m_last = m_word;
                if (m_widx == m_target - 1) begin
                    m_busy = 0;
                    m_dn   = 1;
                end else begin
                    m_widx++;
                end
            end else if (m_dn) begin
                m_dn = 0;
            end else if (m_busy) begin
                if (byte_valid) begin
                    m_q.push_back(byte_data);
                    if (m_q.size() == 4) begin
                        m_word = {m_q[3], m_q[2], m_q[1], m_q[0]};
                        m_q.delete();
                        m_wr = 1;
                    end
                end
            end else if (start) begin
                if (word_count == 0) begin
                    m_dn = 1;
                end else begin
                    m_busy   = 1;
                    m_widx   = 0;
                    m_target = (int'(word_count) > DEPTH) ? DEPTH : int'(word_count);
                end
            end
        end
    endtask

    // ---------------- monitor + per-cycle compare ----------------
    int          wa_q[$];
    logic [31:0] wd_q[$];
    int          wcyc_q[$];
    int          dc_q[$];
    int          hold_cnt = 0;

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (mem_enable === 1'b1) begin
                wa_q.push_back(int'(mem_address));
                wd_q.push_back(mem_data_in);
                wcyc_q.push_back(cyc);
            end
            if (done === 1'b1) dc_q.push_back(cyc);
            if (cpu_hold === 1'b1) hold_cnt++;
            if (m_ok) begin
                check("byte_ready", 32'(byte_ready), 32'(m_busy && !m_wr));
                check("cpu_hold",   32'(cpu_hold),   32'(m_busy));
                check("mem_enable", 32'(mem_enable), 32'(m_wr));
                check("done",       32'(done),       32'(m_dn));
                check("mem_address", 32'(mem_address), m_busy ? 32'(m_widx) : 32'(pc_address));
                if (m_wr)         check("mem_data_in_write", mem_data_in, m_word);
                else if (!m_busy) check("mem_data_in_hold",  mem_data_in, m_last);
            end
        end
    endtask

    // ---------------- stimulus helpers (all start/end at posedge+1) -------
    logic [7:0] stim[1024];

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_start(input int wc, output int s_cyc);
        start = 1'b1;
        word_count = (ADDR_W+1)'(wc);
        s_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_bytes(input int first, input int n, input int mode);
        int  i = 0;
        int  t = 0;
        bit  tog = 1'b1;
        bit  acc;
        int  budget = n * 8 + 50;
        while (i < n && t < budget) begin
            case (mode)
                0:       byte_valid = 1'b1;
                1:       begin byte_valid = tog; tog = !tog; end
                default: byte_valid = ($urandom_range(3) != 0);
            endcase
            byte_data = stim[first + i];
            @(negedge clk);
            acc = byte_valid && byte_ready;
            @(posedge clk); #1;
            if (acc) i++;
            t++;
        end
        byte_valid = 1'b0;
        check("bytes_accepted", 32'(i), 32'(n));
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (t < budget) begin
            @(negedge clk);
            if (done === 1'b1) break;
            t++;
        end
        check("done_within_budget", 32'(t < budget), 32'd1);
        @(posedge clk); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int wb, db, hb, sc, bad;
        fork
            model_loop();
            compare_loop();
        join_none

        // Reset state
        pc_address = 8'h33;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_address", 32'(mem_address), 32'h33);
        check("rst_mem_data_in", mem_data_in, 32'h0);
        check("rst_cpu_hold",    32'(cpu_hold),   32'h0);
        check("rst_byte_ready",  32'(byte_ready), 32'h0);
        check("rst_mem_enable",  32'(mem_enable), 32'h0);
        check("rst_done",        32'(done),       32'h0);
        rst = 1'b0;
        idle(2);

        // Two-word back-to-back load
        stim[0] = 8'h13; stim[1] = 8'h00; stim[2] = 8'h00; stim[3] = 8'h00;
        stim[4] = 8'h93; stim[5] = 8'h00; stim[6] = 8'h10; stim[7] = 8'h00;
        wb = wa_q.size(); db = dc_q.size(); hb = hold_cnt;
        do_start(2, sc);
        send_bytes(0, 8, 0);
        wait_done(20);
        check("two_word_writes", 32'(wa_q.size() - wb), 32'd2);
        if (wa_q.size() - wb >= 2) begin
            check("w0_addr", 32'(wa_q[wb]),   32'd0);
            check("w0_data", wd_q[wb],        32'h0000_0013);
            check("w1_addr", 32'(wa_q[wb+1]), 32'd1);
            check("w1_data", wd_q[wb+1],      32'h0010_0093);
            if (dc_q.size() > db)
                check("done_after_write", 32'(dc_q[db] - wcyc_q[wb+1]), 32'd1);
        end
        check("two_word_done_count", 32'(dc_q.size() - db), 32'd1);
        check("two_word_hold_cycles", 32'(hold_cnt - hb), 32'd10);
        check("model_last_word", m_last, 32'h0010_0093);

        // Zero-length load
        wb = wa_q.size(); db = dc_q.size(); hb = hold_cnt;
        do_start(0, sc);
        wait_done(5);
        check("zero_writes", 32'(wa_q.size() - wb), 32'd0);
        check("zero_done_count", 32'(dc_q.size() - db), 32'd1);
        if (dc_q.size() > db) check("zero_done_latency", 32'(dc_q[db] - sc), 32'd1);
        check("zero_hold_cycles", 32'(hold_cnt - hb), 32'd0);

        // One word, byte_valid toggling
        stim[0] = 8'hAA; stim[1] = 8'hBB; stim[2] = 8'hCC; stim[3] = 8'hDD;
        wb = wa_q.size();
        do_start(1, sc);
        send_bytes(0, 4, 1);
        wait_done(10);
        check("toggle_writes", 32'(wa_q.size() - wb), 32'd1);
        if (wa_q.size() > wb) begin
            check("toggle_addr", 32'(wa_q[wb]), 32'd0);
            check("toggle_data", wd_q[wb],      32'hDDCC_BBAA);
        end

        // Reset in the middle of word 1
        stim[0] = 8'h11; stim[1] = 8'h22; stim[2] = 8'h33;
        stim[3] = 8'h44; stim[4] = 8'h55; stim[5] = 8'h66;
        wb = wa_q.size(); db = dc_q.size();
        do_start(2, sc);
        send_bytes(0, 6, 0);
        pc_address = 8'h5A;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_mem_address", 32'(mem_address), 32'h5A);
        check("abort_cpu_hold",    32'(cpu_hold),    32'd0);
        check("abort_mem_data_in", mem_data_in,      32'd0);
        byte_valid = 1'b1;
        idle(8);
        byte_valid = 1'b0;
        check("abort_writes", 32'(wa_q.size() - wb), 32'd1);
        if (wa_q.size() > wb) check("abort_w0_data", wd_q[wb], 32'h4433_2211);
        check("abort_no_done", 32'(dc_q.size() - db), 32'd0);

        // Oversized load clamps to DEPTH
        for (int i = 0; i < 1024; i++) stim[i] = 8'($urandom);
        wb = wa_q.size(); db = dc_q.size();
        do_start(300, sc);
        send_bytes(0, 1024, 2);
        wait_done(50);
        check("clamp_writes", 32'(wa_q.size() - wb), 32'd256);
        bad = 0;
        for (int i = 0; i < wa_q.size() - wb; i++) if (wa_q[wb+i] != i) bad++;
        check("clamp_sequential", 32'(bad), 32'd0);
        check("clamp_done_count", 32'(dc_q.size() - db), 32'd1);

        // start pulsed during COLLECT is ignored
        wb = wa_q.size(); db = dc_q.size();
        do_start(3, sc);
        send_bytes(0, 2, 0);
        do_start(1, sc);
        send_bytes(2, 10, 0);
        wait_done(20);
        check("ignore_start_writes", 32'(wa_q.size() - wb), 32'd3);
        if (wa_q.size() - wb >= 3) check("ignore_start_last_addr", 32'(wa_q[wb+2]), 32'd2);
        check("ignore_start_done", 32'(dc_q.size() - db), 32'd1);

        // Randomized traffic, checked every cycle against the model
        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(199) == 0);
            start      = ($urandom_range(7) == 0);
            word_count = ($urandom_range(15) == 0) ? (ADDR_W+1)'(300)
                                                   : (ADDR_W+1)'($urandom_range(0, 5));
            byte_valid = ($urandom_range(1) == 0);
            byte_data  = 8'($urandom);
            pc_address = ADDR_W'($urandom);
            @(posedge clk); #1;
        end
        rst = 1'b0; start = 1'b0; byte_valid = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
